mul_progressive_iter: RTL and testbench

- Parametrised, iterative signed fixed-point multiplier with per-transaction selectable precision.
- Lower precision finishes in proportionally fewer cycles; the result is always returned in full-width Q1.(2W-2) alignment.
- Valid/ready handshakes on both sides, one operation in flight at a time.
- Sits between attention-score producers and accumulators wherever precision is traded for latency at run time.

---
 rtl/mul_progressive_iter.sv | 153 +++++++++++++++
 tb/tb_mul_progressive_iter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_progressive_iter.sv
// Iterative signed Q0.(W-1) x Q0.(W-1) multiplier with run-time precision P; optional operand rounding under MUL_PROG_ROUND_EN.
// Latency: P/BPC cycles from accept to out_valid; result always Q1.(2W-2) aligned.
// Backpressure: one op in flight; in_ready low in RUN/DONE, DONE holds until out_ready.
module mul_progressive_iter #(
    parameter int WIDTH = 16,
    parameter int BPC   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_prec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [1:0]           out_prec,
    output logic                 busy
);
    localparam int W  = WIDTH;
    localparam int AW = $clog2(W);
    localparam int CW = (W / BPC > 2) ? $clog2(W / BPC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2*W:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_amt;
    logic [1:0]      r_prec;

    logic [1:0]      w_eff;
    logic [AW-1:0]   w_shift;
    logic [CW-1:0]   w_cnt0;
    logic [W-1:0]    w_a_q;
    logic [W-1:0]    w_b_q;
    logic [W-1:0]    w_b_t;
    logic            w_last;
    logic [BPC:0]    w_slice;
    logic [W+BPC:0]  w_a_ext;
    logic [W+BPC:0]  w_s_ext;
    logic [W+BPC:0]  w_pp;
    logic [2*W:0]    w_term;
    logic [2*W:0]    w_acc_nxt;

    // Reduce an operand to its top P bits, keeping it aligned at the MSB end.
    function automatic logic [W-1:0] quant(input logic [W-1:0] x, input logic [AW-1:0] s);
        logic [W-1:0] mask;
`ifdef MUL_PROG_ROUND_EN
        logic [W:0] sum;
`endif
        mask = {W{1'b1}} << s;
`ifdef MUL_PROG_ROUND_EN
        if (s == '0) begin
            quant = x;
        end else begin
            sum = {x[W-1], x} + ((W+1)'(1) << (s - 1'b1));
            if (sum[W] != sum[W-1])
                quant = {1'b0, {(W-1){1'b1}}} & mask;
            else
                quant = sum[W-1:0] & mask;
        end
`else
        quant = x & mask;
`endif
    endfunction

    always_comb begin
        w_eff = (in_prec == 2'd3) ? 2'd2 : in_prec;
        case (w_eff)
            2'd0:    begin w_shift = AW'(W - W/4); w_cnt0 = CW'(W/4/BPC - 1); end
            2'd1:    begin w_shift = AW'(W - W/2); w_cnt0 = CW'(W/2/BPC - 1); end
            default: begin w_shift = '0;           w_cnt0 = CW'(W/BPC - 1);   end
        endcase
        w_a_q = quant(in_a, w_shift);
        w_b_q = quant(in_b, w_shift);
        w_b_t = w_b_q >> w_shift;
    end

    // The final slice holds b_t's sign bit, so it is taken as a signed digit.
    always_comb begin
        w_last    = (r_cnt == '0);
        w_slice   = w_last ? {r_b[BPC-1], r_b[BPC-1:0]} : {1'b0, r_b[BPC-1:0]};
        w_a_ext   = {{(BPC+1){r_a[W-1]}}, r_a};
        w_s_ext   = {{W{w_slice[BPC]}}, w_slice};
        w_pp      = w_a_ext * w_s_ext;
        w_term    = {{(W-BPC){w_pp[W+BPC]}}, w_pp} << r_amt;
        w_acc_nxt = r_acc + w_term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_result <= '0;
            out_prec   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_amt      <= '0;
            r_prec     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= w_a_q;
                        r_b      <= w_b_t;
                        r_amt    <= w_shift;
                        r_cnt    <= w_cnt0;
                        r_acc    <= '0;
                        r_prec   <= w_eff;
                        r_state  <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= r_b >> BPC;
                    r_amt <= r_amt + AW'(BPC);
                    if (w_last) begin
                        r_state    <= S_DONE;
                        out_valid  <= 1'b1;
                        out_result <= w_acc_nxt[2*W-1:0];
                        out_prec   <= r_prec;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_progressive_iter.sv
// Bench for mul_progressive_iter (WIDTH=16, BPC=2): table vectors, corner sequences, random stream with scoreboard.
module tb_mul_progressive_iter;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  in_prec;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_prec;
    logic        busy;

    mul_progressive_iter #(.WIDTH(16), .BPC(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_prec(in_prec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_prec(out_prec), .busy(busy)
    );

    typedef struct {
        logic [1:0]  prec;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        logic [1:0]  eprec;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  prec;
        int          lat;
        int          acc_cyc;
    } sb_t;

    sb_t         q[$];
    vec_t        vecs[9];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] nxt_exp;
    logic [1:0]  nxt_prec;
    int          nxt_lat;
    bit          rand_mode = 0;
    bit          prev_ov   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint qz(input logic [15:0] x, input int s, input int p);
        longint v;
        v = longint'($signed(x));
        if (s == 0) return v;
`ifdef MUL_PROG_ROUND_EN
        v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (v > (longint'(1) << (p - 1)) - 1) v = (longint'(1) << (p - 1)) - 1;
        return v;
`else
        return v >>> s;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [1:0] pr, input logic [15:0] a, input logic [15:0] b);
        int p, s;
        longint r;
        p = (pr == 2'd0) ? 4 : (pr == 2'd1) ? 8 : 16;
        s = 16 - p;
        r = (qz(a, s, p) * qz(b, s, p)) <<< (2 * s);
        return r[31:0];
    endfunction

    // Monitor: samples on the falling edge what the next rising edge will act on.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_ov = 0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
                else chk("latency", 32'(cyc - q[0].acc_cyc - 1), 32'(q[0].lat));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    chk("result", out_result, q[0].res);
                    chk("out_prec", 32'(out_prec), 32'(q[0].prec));
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back('{res: nxt_exp, prec: nxt_prec, lat: nxt_lat, acc_cyc: cyc});
            prev_ov = out_valid;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [1:0] pr, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        int t;
        nxt_exp  = exp;
        nxt_prec = (pr == 2'd3) ? 2'd2 : pr;
        nxt_lat  = (4 << nxt_prec) / 2;
        in_prec  = pr;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{prec: 2'd2, a: 16'h4000, b: 16'h4000, exp: 32'h10000000, eprec: 2'd2};
        vecs[1] = '{prec: 2'd2, a: 16'h8000, b: 16'h8000, exp: 32'h40000000, eprec: 2'd2};
        vecs[2] = '{prec: 2'd2, a: 16'h8000, b: 16'h4000, exp: 32'hE0000000, eprec: 2'd2};
        vecs[3] = '{prec: 2'd0, a: 16'h7FFF, b: 16'h7FFF, exp: 32'h31000000, eprec: 2'd0};
`ifdef MUL_PROG_ROUND_EN
        vecs[4] = '{prec: 2'd0, a: 16'h3C00, b: 16'h4000, exp: 32'h10000000, eprec: 2'd0};
        vecs[5] = '{prec: 2'd1, a: 16'h1234, b: 16'h00FF, exp: 32'h00120000, eprec: 2'd1};
`else
        vecs[4] = '{prec: 2'd0, a: 16'h3C00, b: 16'h4000, exp: 32'h0C000000, eprec: 2'd0};
        vecs[5] = '{prec: 2'd1, a: 16'h1234, b: 16'h00FF, exp: 32'h00000000, eprec: 2'd1};
`endif
        vecs[6] = '{prec: 2'd1, a: 16'h7FFF, b: 16'h8000, exp: 32'hC0800000, eprec: 2'd1};
        vecs[7] = '{prec: 2'd3, a: 16'hC000, b: 16'h4000, exp: 32'hF0000000, eprec: 2'd2};
        vecs[8] = '{prec: 2'd0, a: 16'h8000, b: 16'h8000, exp: 32'h40000000, eprec: 2'd0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_prec = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_prec", 32'(out_prec), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            send(vecs[i].prec, vecs[i].a, vecs[i].b, vecs[i].exp);
            chk("busy_after_accept", 32'(busy), 32'd1);
            wait_drain();
            chk("vec_out_prec_held", 32'(out_prec), 32'(vecs[i].eprec));
        end

        // Backpressure: DONE holds, new beats are ignored, then exactly one handshake.
        out_ready = 1'b0;
        send(2'd1, 16'h7FFF, 16'h8000, 32'hC0800000);
        for (int t = 0; t < 50 && !out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_prec = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_result", out_result, 32'hC0800000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_no_extra_valid", 32'(out_valid), 32'd0);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);

        // Reset mid-RUN discards the op and clears outputs.
        send(2'd2, 16'h4000, 16'h4000, 32'h10000000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_result", out_result, 32'd0);
        chk("midrst_out_prec", 32'(out_prec), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_partial", 32'(out_valid), 32'd0);
        send(2'd3, 16'h2000, 16'h2000, 32'h04000000);
        wait_drain();
        chk("prec3_out_prec", 32'(out_prec), 32'd2);
        chk("prec3_result_held", out_result, 32'h04000000);

        // Back-to-back random stream with random consumer stalls.
        rand_mode = 1;
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  pr;
            logic [15:0] a, b;
            pr = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (k < 4) begin a = 16'h8000; b = 16'h8000; end
            send(pr, a, b, model(pr, a, b));
        end
        rand_mode = 0;
        out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
